dma_decomp_writer: RTL and testbench
====================================

// Module: dma_decomp_writer
// PURPOSE
//  Run-length bit-stream decompressor with an embedded byte RAM. Each start request carries two
//  RLE tokens, {value, run}. The block expands them MSB-first into RAM at a persistent
//  byte/bit write pointer, using read-modify-write so neighbouring bits are preserved.
//  A host port loads and inspects the RAM. The block sits between the compressed-input decoder
//  and the feature-map buffer consumer.
// PARAMETERS
//  ADDR_W  16  RAM address width; depth = 2**ADDR_W bytes, data fixed at 8 bits
// PORTS
//  clk           in   1       single clock, all logic on posedge
//  RST           in   1       reset, asynchronous and active-high
//  start         in   1       request: decompress tokens in1 then in2 (sampled when idle)
//  in1           in   8       token 1: [7]=bit value, [6:0]=run length 0..127
//  in2           in   8       token 2, same format, processed after in1
//  ptr_load      in   1       when idle: load write pointer from byte_idx_in/bit_idx_in
//  byte_idx_in   in   ADDR_W  byte index to load
//  bit_idx_in    in   3       bit index to load (7 = MSB = first bit written)
//  new_byte_idx  out  ADDR_W  current write-pointer byte
//  new_bit_idx   out  3       current write-pointer bit (next bit to write)
//  busy          out  1       request in progress
//  done          out  1       one-cycle pulse when request completes
//  mem_we        in   1       host write mem[mem_addr]=mem_wdata (idle only)
//  mem_rd        in   1       host read; mem_rdata valid next cycle (idle only)
//  mem_addr      in   ADDR_W  host address
//  mem_wdata     in   8       host write data
//  mem_rdata     out  8       host read data; holds its value until the next host read
// BEHAVIOUR
//  - Reset: new_byte_idx=0, new_bit_idx=7, busy=0, done=0, mem_rdata=0, FSM=IDLE. RAM not reset.
//  - Bit order: linear position = byte*8 + (7-bit). A run of N advances the position by N.
//    new_bit = (bit - N) mod 8; new_byte = (byte*8 + 7 - bit + N) / 8, mod 2**ADDR_W.
//  - Requests: IDLE accepts start. If ptr_load is asserted in the same cycle, the loaded
//    pointer is applied first. in1/in2 are latched. busy=1 from the next cycle.
//  - start, ptr_load, mem_we and mem_rd are ignored while busy.
//  - FSM: IDLE -> SEL -> (RD -> WR)* -> SEL ... -> DONE -> IDLE.
//    SEL: picks the next token; a run of 0 is skipped. After token 2, SEL goes to DONE.
//    RD: issue RAM read of the pointer byte.
//    WR: k = min(remaining, bit+1) bits. Write bits bit..bit-k+1 with the token value and keep
//      all other bits from the read data. Then write the byte, advance the pointer by k and
//      decrement remaining by k. Go to RD while remaining>0, else to SEL.
//    DONE: done=1 for exactly one cycle, busy=0 on the following cycle.
//  - Latency: 2 cycles per touched byte, plus SEL/DONE overhead. Two zero-length tokens
//    complete with no RAM write.
//  - Pointer outputs update on the WR edge of each chunk.
//  - Byte address wraps from 2**ADDR_W-1 to 0.
//  - Reset mid-request aborts: bytes already written stay written; pointer returns to 0/7.
//  - RAM: single port, synchronous read with 1-cycle latency. FSM owns the port while busy,
//    the host owns it while idle.
// CONFIGURATION
//  DMA_DECOMP_FASTFILL_EN defined: in SEL/WR, a chunk with bit==7 and remaining>=8 skips RD.
//    It writes 0xFF (value 1) or 0x00 (value 0) directly, costing 1 cycle per byte.
//  Undefined: every byte uses RD->WR.
//  RAM contents and pointers are identical either way; only the cycle count differs.
// STRUCTURE
//  Package dma_decomp_pkg: FSM state enum, token field positions (VAL_BIT=7, RUN_MSB=6),
//    RUN_W=7.
//  Sub-module dma_decomp_ram: 2**ADDR_W x 8 single-port RAM with sync read and write enable.
//  Top: FSM, pointer and remaining counters, merge mask, host/FSM port mux.
// TESTING
//  1 Reset -> new_byte_idx=0, new_bit_idx=7, busy=0, done=0.
//  2 RAM zeroed, ptr 0/7, in1=0x85, in2=0x00 -> mem[0]=0xF8, ptr 0/2, single done pulse.
//  3 mem[2]=0xA8, mem[3]=0xFF, load ptr 2/2, in1=0x86, in2=0x03 -> mem[2]=0xAF,
//    mem[3]=0xE3, ptr 3/1.
//  4 RAM zeroed, ptr 0/7, in1=0xFF, in2=0x01 -> mem[0..14]=0xFF, mem[15]=0xFE, ptr 16/7.
//    Cycle count must differ with and without DMA_DECOMP_FASTFILL_EN.
//  5 in1=0x80, in2=0x00 -> no RAM change, ptr unchanged, done pulses.
//    A start issued while busy is ignored.
//  6 Zeroed RAM, load ptr 0xFFFF/3, in1=0x86 -> mem[0xFFFF]=0x0F, mem[0]=0xC0, ptr 0/5.
//    RST pulse mid-run -> ptr 0/7, busy=0.

Source files
------------

// File: rtl/dma_decomp_pkg.sv
// Shared types and token layout for the run-length decompressor.
package dma_decomp_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SEL  = 3'd1,
        RD   = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } stateT;

    localparam int VAL_BIT = 7;
    localparam int RUN_MSB = 6;
    localparam int RUN_W   = 7;

    // Mask covering k bits starting at bitIdx and running toward the LSB.
    function automatic logic [7:0] chunkMask(input logic [2:0] bitIdx, input logic [3:0] k);
        logic [7:0] top;
        top = 8'hFF << (4'd8 - k);
        return top >> (3'd7 - bitIdx);
    endfunction

endpackage

// File: rtl/dma_decomp_writer_if.sv
// Request, pointer and host-memory signals of the decompressor.
interface dma_decomp_writer_if #(parameter int ADDR_W = 16);
    logic              start;
    logic [7:0]        in1;
    logic [7:0]        in2;
    logic              ptr_load;
    logic [ADDR_W-1:0] byte_idx_in;
    logic [2:0]        bit_idx_in;
    logic [ADDR_W-1:0] new_byte_idx;
    logic [2:0]        new_bit_idx;
    logic              busy;
    logic              done;
    logic              mem_we;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    modport master (
        output start, in1, in2, ptr_load, byte_idx_in, bit_idx_in,
               mem_we, mem_rd, mem_addr, mem_wdata,
        input  new_byte_idx, new_bit_idx, busy, done, mem_rdata
    );

    modport slave (
        input  start, in1, in2, ptr_load, byte_idx_in, bit_idx_in,
               mem_we, mem_rd, mem_addr, mem_wdata,
        output new_byte_idx, new_bit_idx, busy, done, mem_rdata
    );
endinterface

// File: rtl/dma_decomp_ram.sv
// Single-port byte RAM, synchronous write and read (read data one cycle later).
module dma_decomp_ram #(parameter int ADDR_W = 16) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata
);
    logic [7:0] mem [2**ADDR_W];

    // Write and registered read share the one address.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        if (re) rdata <= mem[addr];
    end
endmodule

// File: rtl/dma_decomp_writer.sv
// Run-length bit-stream decompressor writing MSB-first into an embedded byte RAM.
// Optional macro DMA_DECOMP_FASTFILL_EN: whole-byte chunks skip the read and are
// written as 0xFF/0x00 in one cycle. Results are identical, only latency changes.
//
// state | meaning
// IDLE  | host owns RAM, accepts start / ptr_load
// SEL   | pick next token, skip zero runs, DONE after token 2
// RD    | read the byte under the write pointer
// WR    | merge chunk into read data, write, advance pointer
// DONE  | one-cycle completion pulse
module dma_decomp_writer
    import dma_decomp_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic                 clk,
    input  logic                 RST,
    dma_decomp_writer_if.slave   bus
);
`ifdef DMA_DECOMP_FASTFILL_EN
    localparam bit FAST_EN = 1'b1;
`else
    localparam bit FAST_EN = 1'b0;
`endif

    stateT             state, nextState;
    logic [ADDR_W-1:0] bytePtr;
    logic [2:0]        bitPtr;
    logic [7:0]        tok1, tok2;
    logic [1:0]        tokIdx;
    logic              curVal;
    logic [RUN_W-1:0]  remaining;
    logic              hostRdPend;
    logic [7:0]        hostHold;

    logic [7:0]        selTok;
    logic [RUN_W-1:0]  selRun;
    logic [3:0]        bitsAvail, chunk;
    logic [RUN_W-1:0]  remAfter;
    logic [ADDR_W+2:0] linNow, linAfter;
    logic [7:0]        mask, ramQ, wrData;
    logic              fastFromSel, fastFromWr;
    logic              isIdle;

    assign isIdle      = (state == IDLE);
    assign selTok      = (tokIdx == 2'd0) ? tok1 : tok2;
    assign selRun      = selTok[RUN_MSB:0];
    assign bitsAvail   = {1'b0, bitPtr} + 4'd1;
    assign chunk       = (remaining < {3'b000, bitsAvail}) ? remaining[3:0] : bitsAvail;
    assign remAfter    = remaining - {3'b000, chunk};
    assign linNow      = {bytePtr, 3'd7 - bitPtr};
    assign linAfter    = linNow + {{(ADDR_W-1){1'b0}}, chunk};
    assign mask        = chunkMask(bitPtr, chunk);
    assign wrData      = curVal ? (ramQ | mask) : (ramQ & ~mask);
    assign fastFromSel = FAST_EN && (bitPtr == 3'd7) && (selRun >= 7'd8);
    assign fastFromWr  = FAST_EN && (linAfter[2:0] == 3'd0) && (remAfter >= 7'd8);

    // State register.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= nextState;
    end

    // Next-state decode.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (bus.start) nextState = SEL;
            SEL: begin
                if (tokIdx == 2'd2)       nextState = DONE;
                else if (selRun != '0)    nextState = fastFromSel ? WR : RD;
            end
            RD:   nextState = WR;
            WR: begin
                if (remAfter != '0) nextState = fastFromWr ? WR : RD;
                else                nextState = SEL;
            end
            DONE: nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Pointer, token and run-length bookkeeping.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            bytePtr   <= '0;
            bitPtr    <= 3'd7;
            tok1      <= '0;
            tok2      <= '0;
            tokIdx    <= '0;
            curVal    <= 1'b0;
            remaining <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.ptr_load) begin
                        bytePtr <= bus.byte_idx_in;
                        bitPtr  <= bus.bit_idx_in;
                    end
                    if (bus.start) begin
                        tok1   <= bus.in1;
                        tok2   <= bus.in2;
                        tokIdx <= 2'd0;
                    end
                end
                SEL: begin
                    if (tokIdx != 2'd2) begin
                        tokIdx    <= tokIdx + 2'd1;
                        curVal    <= selTok[VAL_BIT];
                        remaining <= selRun;
                    end
                end
                WR: begin
                    bytePtr   <= linAfter[ADDR_W+2:3];
                    bitPtr    <= 3'd7 - linAfter[2:0];
                    remaining <= remAfter;
                end
                default: ;
            endcase
        end
    end

    // Host read data: live for the cycle after a read, then held.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            hostRdPend <= 1'b0;
            hostHold   <= '0;
        end else begin
            hostRdPend <= isIdle && bus.mem_rd;
            if (hostRdPend) hostHold <= ramQ;
        end
    end

    dma_decomp_ram #(.ADDR_W(ADDR_W)) uRam (
        .clk   (clk),
        .we    (isIdle ? bus.mem_we    : (state == WR)),
        .re    (isIdle ? bus.mem_rd    : (state == RD)),
        .addr  (isIdle ? bus.mem_addr  : bytePtr),
        .wdata (isIdle ? bus.mem_wdata : wrData),
        .rdata (ramQ)
    );

    assign bus.new_byte_idx = bytePtr;
    assign bus.new_bit_idx  = bitPtr;
    assign bus.busy         = !isIdle;
    assign bus.done         = (state == DONE);
    assign bus.mem_rdata    = hostRdPend ? ramQ : hostHold;
endmodule

// File: tb/tb_dma_decomp_writer.sv
// Directed bench for dma_decomp_writer with hand-computed expectations.
module tb_dma_decomp_writer;
    logic clk = 1'b0;
    logic RST = 1'b1;
    int   nChecks = 0;
    int   nFails  = 0;

    always #5 clk = ~clk;

    dma_decomp_writer_if #(.ADDR_W(16)) bus ();
    dma_decomp_writer #(.ADDR_W(16)) dut (.clk(clk), .RST(RST), .bus(bus));

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic hostWrite(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.mem_we = 1'b1; bus.mem_addr = a; bus.mem_wdata = d;
        @(posedge clk);
        @(negedge clk);
        bus.mem_we = 1'b0;
    endtask

    task automatic hostRead(input logic [15:0] a, output logic [7:0] d);
        @(negedge clk);
        bus.mem_rd = 1'b1; bus.mem_addr = a;
        @(posedge clk);
        @(negedge clk);
        bus.mem_rd = 1'b0;
        d = bus.mem_rdata;
    endtask

    task automatic checkMem(input string tag, input logic [15:0] a, input logic [7:0] exp);
        logic [7:0] d;
        hostRead(a, d);
        checkVal(tag, {24'd0, d}, {24'd0, exp});
    endtask

    // Issues a request and waits for done. pokeAt >= 0 drives start/ptr_load/mem_we
    // for one cycle at that point of the run; all of it must be ignored while busy.
    task automatic runReq(input logic [7:0] t1, input logic [7:0] t2, input logic ld,
                          input logic [15:0] bIdx, input logic [2:0] bBit, input int pokeAt,
                          output int cyc, output int pulses);
        logic seen;
        @(negedge clk);
        bus.start = 1'b1; bus.in1 = t1; bus.in2 = t2;
        bus.ptr_load = ld; bus.byte_idx_in = bIdx; bus.bit_idx_in = bBit;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0; bus.ptr_load = 1'b0;
        cyc = 0; pulses = 0; seen = 1'b0;
        while (!seen && cyc < 400) begin
            if (cyc == pokeAt) begin
                bus.start = 1'b1; bus.in1 = 8'h00; bus.in2 = 8'h00;
                bus.ptr_load = 1'b1; bus.byte_idx_in = 16'h0100; bus.bit_idx_in = 3'd0;
                bus.mem_we = 1'b1; bus.mem_addr = 16'h0000; bus.mem_wdata = 8'h55;
            end
            @(posedge clk);
            @(negedge clk);
            bus.start = 1'b0; bus.ptr_load = 1'b0; bus.mem_we = 1'b0;
            cyc++;
            if (bus.done) begin
                pulses++;
                seen = 1'b1;
            end
        end
        checkVal("doneSeen", {31'd0, seen}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        checkVal("busyAfterDone", {31'd0, bus.busy}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            if (bus.done) pulses++;
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic checkPtr(input string tag, input logic [15:0] b, input logic [2:0] bt);
        checkVal({tag, "_byte"}, {16'd0, bus.new_byte_idx}, {16'd0, b});
        checkVal({tag, "_bit"},  {29'd0, bus.new_bit_idx},  {29'd0, bt});
    endtask

    initial begin
        int cyc, pulses;
        logic [7:0] d;
        bus.start = 0; bus.in1 = 0; bus.in2 = 0; bus.ptr_load = 0;
        bus.byte_idx_in = 0; bus.bit_idx_in = 0;
        bus.mem_we = 0; bus.mem_rd = 0; bus.mem_addr = 0; bus.mem_wdata = 0;

        // Reset state
        repeat (3) @(negedge clk);
        checkPtr("rst", 16'd0, 3'd7);
        checkVal("rst_busy",  {31'd0, bus.busy}, 32'd0);
        checkVal("rst_done",  {31'd0, bus.done}, 32'd0);
        checkVal("rst_rdata", {24'd0, bus.mem_rdata}, 32'd0);
        RST = 1'b0;

        for (int a = 0; a <= 16; a++) hostWrite(16'(a), 8'h00);
        hostWrite(16'hFFFF, 8'h00);

        // Single token, 5 ones from 0/7
        runReq(8'h85, 8'h00, 1'b1, 16'd0, 3'd7, -1, cyc, pulses);
        checkVal("t2_cycles", cyc, 32'd5);
        checkVal("t2_pulses", pulses, 32'd1);
        checkPtr("t2", 16'd0, 3'd2);
        checkMem("t2_mem0", 16'd0, 8'hF8);

        // Merge into existing bytes, two tokens, crosses a byte
        hostWrite(16'd2, 8'hA8);
        hostWrite(16'd3, 8'hFF);
        runReq(8'h86, 8'h03, 1'b1, 16'd2, 3'd2, -1, cyc, pulses);
        checkVal("t3_cycles", cyc, 32'd9);
        checkPtr("t3", 16'd3, 3'd1);
        checkMem("t3_mem2", 16'd2, 8'hAF);
        checkMem("t3_mem3", 16'd3, 8'hE3);

        // Long run with ignored start/ptr_load/host write mid-run
        for (int a = 0; a <= 16; a++) hostWrite(16'(a), 8'h00);
        runReq(8'hFF, 8'h01, 1'b1, 16'd0, 3'd7, 4, cyc, pulses);
`ifdef DMA_DECOMP_FASTFILL_EN
        checkVal("t4_cycles", cyc, 32'd22);
`else
        checkVal("t4_cycles", cyc, 32'd37);
`endif
        checkVal("t4_pulses", pulses, 32'd1);
        checkPtr("t4", 16'd16, 3'd7);
        for (int a = 0; a <= 14; a++) checkMem($sformatf("t4_mem%0d", a), 16'(a), 8'hFF);
        checkMem("t4_mem15", 16'd15, 8'hFE);
        checkMem("t4_mem16", 16'd16, 8'h00);

        // Two zero-length tokens: no write, pointer kept
        hostWrite(16'd16, 8'h5A);
        runReq(8'h80, 8'h00, 1'b0, 16'd0, 3'd0, -1, cyc, pulses);
        checkVal("t5_cycles", cyc, 32'd3);
        checkVal("t5_pulses", pulses, 32'd1);
        checkPtr("t5", 16'd16, 3'd7);
        checkMem("t5_mem16", 16'd16, 8'h5A);

        // Read data holds across a host write
        hostWrite(16'd20, 8'h33);
        checkVal("rdata_hold", {24'd0, bus.mem_rdata}, 32'h5A);

        // Address wrap
        hostWrite(16'hFFFF, 8'h00);
        hostWrite(16'd0, 8'h00);
        runReq(8'h86, 8'h00, 1'b1, 16'hFFFF, 3'd3, -1, cyc, pulses);
        checkVal("t6_cycles", cyc, 32'd7);
        checkPtr("t6", 16'd0, 3'd5);
        checkMem("t6_memFFFF", 16'hFFFF, 8'h0F);
        checkMem("t6_mem0", 16'd0, 8'hC0);

        // Reset mid-run
        @(negedge clk);
        bus.start = 1'b1; bus.in1 = 8'hFF; bus.in2 = 8'hFF;
        bus.ptr_load = 1'b1; bus.byte_idx_in = 16'd5; bus.bit_idx_in = 3'd7;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0; bus.ptr_load = 1'b0;
        repeat (5) @(negedge clk);
        checkVal("t6_busyMid", {31'd0, bus.busy}, 32'd1);
        RST = 1'b1;
        #1;
        checkPtr("t6_rst", 16'd0, 3'd7);
        checkVal("t6_rst_busy", {31'd0, bus.busy}, 32'd0);
        checkVal("t6_rst_done", {31'd0, bus.done}, 32'd0);
        @(negedge clk);
        RST = 1'b0;
        checkMem("t6_partial", 16'd5, 8'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end
endmodule
